div: RTL and testbench
======================

# div

Multi-cycle 32-bit integer divider for the execute stage, serving the DIV/DIVU instructions. The execute stage launches an operation with start_i and holds the pipeline with a stall request until ready_o rises. It then forwards the 64-bit result (remainder, quotient) as the HI/LO write data into the EX/MEM pipeline register. The divider uses radix-2 restoring division with a 4-state FSM, can be aborted by pipeline flush, and delivers a fixed latency independent of operand values.

## Interface
- No parameters; widths come from the shared define file (RegisterBus = 32, DoubleRegisterBus = 64).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed DIV, 0 = DIVU; sampled with start.
- opdata1_i  in  32  dividend; sampled only at start.
- opdata2_i  in  32  divisor; sampled only at start.
- start_i  in  1  request; held high by execute stage until ready_o is observed.
- annul_i  in  1  abort (pipeline flush); has priority over start_i.
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1, zero otherwise.
- ready_o  out  1  result valid.

## Operation
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END. Reset: DIV_FREE, ready_o=0, result_o=0, cnt=0, internal regs 0.
- FREE:
  - annul_i=1 → stay FREE.
  - start_i=1 with opdata2_i=0 → BY_ZERO.
  - start_i=1 with opdata2_i≠0 → ON; latch |dividend| and |divisor| (absolute values only when signed_div_i=1 and operand negative), latch signs and signed flag, cnt=0, 65-bit work reg = {32'b0, |dividend|, 1'b0}.
- BY_ZERO: unconditionally → END with result 0.
- ON:
  - annul_i=1 → FREE, ready_o=0, result_o=0.
  - Otherwise, while cnt<32: compute 33-bit diff = work[63:32] − {1'b0,|divisor|}. Negative → work = work<<1. Non-negative → work = {diff[31:0], work[31:0], 1'b1}. Increment cnt.
  - cnt==32: quotient = work[31:0], remainder = work[64:33]. If signed, negate the quotient when the operand signs differ, and negate the remainder when the dividend is negative. Register the result, assert ready_o, → END.
- start_i toggling during ON is ignored; only annul_i aborts.
- END: start_i=0 → FREE, ready_o=0, result_o=0. start_i=1 → hold END, result_o and ready_o stable. annul_i is ignored in END.
- Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (no trap).
- Reset mid-operation returns to FREE with all outputs zero at the next edge.

## Timing
- Let E0 be the edge at which FREE samples start_i=1.
- Nonzero divisor: iterations at E1..E32; ready_o=1 after E33. This gives 33 edges of latency regardless of operands.
- Zero divisor: ready_o=1 after E2.
- ready_o stays high until the first edge in END that samples start_i=0. It falls after that edge.
- Back-to-back operations: earliest next start is sampled in FREE, one edge after ready_o falls.
- No combinational path from inputs to outputs; outputs are registered.

## Configuration
- DIV_SIGNED_EN defined: signed_div_i honoured as above.
- DIV_SIGNED_EN undefined: signed_div_i ignored. All operations are unsigned, and sign/negation logic is removed. Latency is unchanged.

## Structure
- Shared define file adds:
  - state codes DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11;
  - DivResultReady/DivResultNotReady, DivStart/DivStop;
  - the DIV_SIGNED_EN switch.
- Single flat module; no sub-module is warranted because the iteration step is one 33-bit subtract and mux.

## Test plan
- Unsigned 100 / 7, start held: ready_o rises after E33, result_o = {32'd2, 32'd14}; drop start → ready_o=0, result_o=0 next edge.
- Signed −7 / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. With DIV_SIGNED_EN undefined, the same operands give quotient 0x7FFFFFFC, remainder 1.
- Divide by zero, 5 / 0: ready_o=1 after E2, result_o=0.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Unsigned: quotient 0, remainder 0x80000000.
- annul_i pulsed at E10 of an operation: FREE next edge, ready_o never rises. A new 9 / 3 start then returns {0, 3} after 33 edges.
- rst asserted at E20: outputs zero next edge, state FREE; start ignored while rst=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the execute-stage divider.
//
// Contents:
//   RegisterBus / DoubleRegisterBus  operand and result widths (32 / 64)
//   div_state_e                      FSM state codes DivFree..DivEnd
//   DivResultReady/NotReady          levels of ready_o
//   DivStart/DivStop                 levels of start_i
//   neg32()                          two's-complement negate helper
//
// Build switch: define DIV_SIGNED_EN (e.g. +define+DIV_SIGNED_EN) to enable
// signed DIV support; leave it undefined for an unsigned-only divider.
package div_pkg;

    localparam int unsigned RegisterBus       = 32;
    localparam int unsigned DoubleRegisterBus = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    function automatic logic [RegisterBus-1:0] neg32(input logic [RegisterBus-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = signed DIV, 0 = DIVU (sampled at start)
//   opdata1_i     dividend (sampled at start)
//   opdata2_i     divisor  (sampled at start)
//   start_i       request, held until ready_o is seen
//   annul_i       abort from pipeline flush
//   result_o      {remainder, quotient}; zero unless ready_o
//   ready_o       result valid
//
// Latency is fixed: 33 edges after the start edge for a nonzero divisor,
// 2 edges for a zero divisor.
//
// Build switch: DIV_SIGNED_EN. When undefined, signed_div_i is ignored and
// all sign handling is removed.
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic [63:0] result_d;
    logic        ready_d;

    logic [31:0] abs_op1;
    logic [31:0] abs_op2;
    logic [32:0] diff;
    logic [31:0] quot;
    logic [31:0] rem;

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;
    logic op1_neg;
    logic op2_neg;

    assign op1_neg = signed_div_i & opdata1_i[31];
    assign op2_neg = signed_div_i & opdata2_i[31];
    assign abs_op1 = op1_neg ? neg32(opdata1_i) : opdata1_i;
    assign abs_op2 = op2_neg ? neg32(opdata2_i) : opdata2_i;
`else
    logic unused_signed_div;

    assign unused_signed_div = signed_div_i;
    assign abs_op1           = opdata1_i;
    assign abs_op2           = opdata2_i;
`endif

    // Trial subtraction; bit 32 set means the partial remainder is too small.
    assign diff = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        result_d  = result_o;
        ready_d   = ready_o;
`ifdef DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        quot = work_q[31:0];
        rem  = work_q[64:33];
`ifdef DIV_SIGNED_EN
        if (neg_quot_q) quot = neg32(work_q[31:0]);
        if (neg_rem_q)  rem  = neg32(work_q[64:33]);
`endif

        unique case (state_q)
            DivFree: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else if (start_i == DivStart) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        cnt_d     = 6'd0;
                        divisor_d = abs_op2;
                        work_d    = {32'd0, abs_op1, 1'b0};
`ifdef DIV_SIGNED_EN
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
`endif
                    end
                end
            end

            DivByZero: begin
                state_d  = DivEnd;
                result_d = 64'd0;
            end

            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    cnt_d    = 6'd0;
                    ready_d  = DivResultNotReady;
                    result_d = 64'd0;
                end else if (cnt_q != 6'd32) begin
                    if (diff[32]) begin
                        work_d = {work_q[63:0], 1'b0};
                    end else begin
                        work_d = {diff[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = DivEnd;
                    cnt_d    = 6'd0;
                    result_d = {rem, quot};
                    ready_d  = DivResultReady;
                end
            end

            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = 64'd0;
                end else begin
                    // Already set on the normal path; raises ready for divide-by-zero.
                    ready_d = DivResultReady;
                end
            end

            default: begin
                state_d = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            result_o  <= 64'd0;
            ready_o   <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            result_o  <= result_d;
            ready_o   <= ready_d;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases from the test plan followed by
// randomized operations, all checked against an arithmetic reference model.
module tb_div;

`ifdef DIV_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {remainder, quotient} from plain arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'd0) return 64'd0;
        if (s && SignedEn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        logic [63:0] exp;
        int          exp_lat;
        int          n;
        bit          early;
        exp     = model(a, b, s);
        exp_lat = (b == 32'd0) ? 2 : 33;
        n       = 0;
        early   = 1'b0;
        @(negedge clk);
        op1        = a;
        op2        = b;
        signed_div = s;
        start      = 1'b1;
        @(posedge clk);  // E0
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                n = i;
                break;
            end
            if (result !== 64'd0) early = 1'b1;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " result"}, result, exp);
        check({tag, " result zero before ready"}, {63'd0, early}, 64'd0);
        // END must hold while start stays high and ignore annul and new operands.
        @(negedge clk);
        op1   = $urandom;
        op2   = $urandom;
        annul = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " hold"}, {ready, result[62:0]}, {1'b1, exp[62:0]});
        check({tag, " hold msb"}, {63'd0, result[63]}, {63'd0, exp[63]});
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " release"}, {ready, result[62:0]}, 64'd0);
    endtask

    initial begin
        bit rose;
        logic [31:0] ra;
        logic [31:0] rb;
        rst        = 1'b1;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        op1        = 32'd0;
        op2        = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", result, 64'd0);
        check("reset ready", {63'd0, ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("u 100/7", 32'd100, 32'd7, 1'b0);
        run_op("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("u -7/2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div0 5/0", 32'd5, 32'd0, 1'b0);
        run_op("s div0", 32'hFFFF_FFF0, 32'd0, 1'b1);
        run_op("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("u min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Flush at E10.
        @(negedge clk);
        op1        = 32'd1000;
        op2        = 32'd3;
        signed_div = 1'b0;
        start      = 1'b1;
        @(posedge clk);  // E0
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);  // E10
        #1;
        check("annul outputs", {ready, result[62:0]}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        rose  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) rose = 1'b1;
        end
        check("annul no ready", {63'd0, rose}, 64'd0);
        run_op("9/3 after annul", 32'd9, 32'd3, 1'b0);

        // Reset at E20, start still held.
        @(negedge clk);
        op1   = 32'd12345;
        op2   = 32'd17;
        start = 1'b1;
        @(posedge clk);  // E0
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);  // E20
        #1;
        check("mid reset outputs", {ready, result[62:0]}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready || result != 64'd0) begin
                check("start ignored in reset", {ready, result[62:0]}, 64'd0);
                break;
            end
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        run_op("after reset", 32'd12345, 32'd17, 1'b0);

        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'd0 - 32'($urandom_range(1, 9));
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if (rb == 32'd0 && $urandom_range(0, 1) == 1) rb = 32'd1;
            run_op($sformatf("rand%0d", k), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
